// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of a shared combinational ALU,
// with a two-stage issue/result pipeline.
//   CLK, RST (sync, active high)
//   reqN_valid/ready/aluop/porta/portb  : request channels, N = 0, 1
//   respN_valid/ready/out/negative/overflow/zero : response channels
//   alu_aluop/porta/portb -> ALU, alu_outputport/negative/overflow/zero <- ALU
//   Parameter RST_PRIO: requester preferred after reset.
//   Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win a tie.
module alu_arbiter #(
   parameter logic RST_PRIO = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_aluop,
   input  logic [31:0] req0_porta,
   input  logic [31:0] req0_portb,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_aluop,
   input  logic [31:0] req1_porta,
   input  logic [31:0] req1_portb,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_out,
   output logic        resp0_negative,
   output logic        resp0_overflow,
   output logic        resp0_zero,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_out,
   output logic        resp1_negative,
   output logic        resp1_overflow,
   output logic        resp1_zero,
   output logic [3:0]  alu_aluop,
   output logic [31:0] alu_porta,
   output logic [31:0] alu_portb,
   input  logic [31:0] alu_outputport,
   input  logic        alu_negative,
   input  logic        alu_overflow,
   input  logic        alu_zero
);
   logic        s1_valid_q, s1_valid_d;
   logic [3:0]  s1_op_q, s1_op_d;
   logic [31:0] s1_a_q, s1_a_d;
   logic [31:0] s1_b_q, s1_b_d;
   logic        s1_tag_q, s1_tag_d;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] s2_out_q, s2_out_d;
   logic [2:0]  s2_flags_q, s2_flags_d;
   logic        s2_tag_q, s2_tag_d;
   logic        ptr_q, ptr_d;
   logic        s2_drain, s2_load, s1_load, gnt0, gnt1, accept;

   assign s2_drain = s2_valid_q && (s2_tag_q ? resp1_ready : resp0_ready);
   assign s2_load  = s1_valid_q && (!s2_valid_q || s2_drain);
   assign s1_load  = !s1_valid_q || s2_load;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign gnt0 = req0_valid;
   assign gnt1 = req1_valid && !req0_valid;
`else
   assign gnt0 = req0_valid && (!req1_valid || !ptr_q);
   assign gnt1 = req1_valid && (!req0_valid || ptr_q);
`endif

   assign req0_ready = gnt0 && s1_load && !RST;
   assign req1_ready = gnt1 && s1_load && !RST;
   assign accept     = req0_ready || req1_ready;

   always_comb begin
      s1_valid_d = s1_load ? accept : s1_valid_q;
      s1_op_d    = !s1_load ? s1_op_q : req1_ready ? req1_aluop : req0_ready ? req0_aluop : '0;
      s1_a_d     = !s1_load ? s1_a_q  : req1_ready ? req1_porta : req0_ready ? req0_porta : '0;
      s1_b_d     = !s1_load ? s1_b_q  : req1_ready ? req1_portb : req0_ready ? req0_portb : '0;
      s1_tag_d   = s1_load ? req1_ready : s1_tag_q;
      // A drain and a load on the same edge keep S2 full with the new result.
      s2_valid_d = s2_load ? 1'b1 : s2_drain ? 1'b0 : s2_valid_q;
      s2_out_d   = s2_load ? alu_outputport : s2_out_q;
      s2_flags_d = s2_load ? {alu_negative, alu_overflow, alu_zero} : s2_flags_q;
      s2_tag_d   = s2_load ? s1_tag_q : s2_tag_q;
      // Pointer names the loser of the last accepted request.
      ptr_d      = accept ? !req1_ready : ptr_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_tag_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_out_q   <= '0;
         s2_flags_q <= '0;
         s2_tag_q   <= 1'b0;
         ptr_q      <= RST_PRIO;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_out_q   <= s2_out_d;
         s2_flags_q <= s2_flags_d;
         s2_tag_q   <= s2_tag_d;
         ptr_q      <= ptr_d;
      end
   end

   assign alu_aluop = s1_valid_q ? s1_op_q : '0;
   assign alu_porta = s1_valid_q ? s1_a_q : '0;
   assign alu_portb = s1_valid_q ? s1_b_q : '0;

   assign resp0_valid    = s2_valid_q && !s2_tag_q;
   assign resp1_valid    = s2_valid_q && s2_tag_q;
   assign resp0_out      = resp0_valid ? s2_out_q : '0;
   assign resp1_out      = resp1_valid ? s2_out_q : '0;
   assign resp0_negative = resp0_valid && s2_flags_q[2];
   assign resp0_overflow = resp0_valid && s2_flags_q[1];
   assign resp0_zero     = resp0_valid && s2_flags_q[0];
   assign resp1_negative = resp1_valid && s2_flags_q[2];
   assign resp1_overflow = resp1_valid && s2_flags_q[1];
   assign resp1_zero     = resp1_valid && s2_flags_q[0];
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a reference ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4;
   logic        CLK = 1'b0, RST = 1'b1;
   logic        req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
   logic [3:0]  req0_aluop = 0, req1_aluop = 0;
   logic [31:0] req0_porta = 0, req0_portb = 0, req1_porta = 0, req1_portb = 0;
   logic        resp0_valid, resp0_ready = 1, resp0_negative, resp0_overflow, resp0_zero;
   logic        resp1_valid, resp1_ready = 1, resp1_negative, resp1_overflow, resp1_zero;
   logic [31:0] resp0_out, resp1_out;
   logic [3:0]  alu_aluop;
   logic [31:0] alu_porta, alu_portb, alu_outputport;
   logic        alu_negative, alu_overflow, alu_zero;
   int checks = 0, fails = 0;

   alu_arbiter #(.RST_PRIO(1'b0)) dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
      .req0_porta(req0_porta), .req0_portb(req0_portb),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
      .req1_porta(req1_porta), .req1_portb(req1_portb),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_out(resp0_out),
      .resp0_negative(resp0_negative), .resp0_overflow(resp0_overflow), .resp0_zero(resp0_zero),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_out(resp1_out),
      .resp1_negative(resp1_negative), .resp1_overflow(resp1_overflow), .resp1_zero(resp1_zero),
      .alu_aluop(alu_aluop), .alu_porta(alu_porta), .alu_portb(alu_portb),
      .alu_outputport(alu_outputport), .alu_negative(alu_negative),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      alu_outputport = alu_aluop == ALU_SUB ? alu_porta - alu_portb :
                       alu_aluop == ALU_AND ? alu_porta & alu_portb :
                       alu_aluop == ALU_OR  ? alu_porta | alu_portb :
                       alu_aluop == ALU_XOR ? alu_porta ^ alu_portb : alu_porta + alu_portb;
      alu_negative = alu_outputport[31];
      alu_zero     = alu_outputport == 32'd0;
      alu_overflow = alu_aluop == ALU_ADD ? (alu_porta[31] == alu_portb[31] && alu_outputport[31] != alu_porta[31]) :
                     alu_aluop == ALU_SUB ? (alu_porta[31] != alu_portb[31] && alu_outputport[31] != alu_porta[31]) : 1'b0;
   end

   task tick;
      @(posedge CLK);
      #1;
   endtask

   task drive(input int i, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (i == 0) begin
         req0_valid = v; req0_aluop = op; req0_porta = a; req0_portb = b;
      end else begin
         req1_valid = v; req1_aluop = op; req1_porta = a; req1_portb = b;
      end
   endtask

   task test_reset;
      RST = 1;
      drive(0, 1, ALU_ADD, 3, 4);
      drive(1, 1, ALU_ADD, 5, 6);
      #1;
      checks++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
      tick;
      tick;
      RST = 0;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      #1;
      checks++; if (resp0_valid !== 1'b0) begin fails++; $display("FAIL rst_resp0_valid: got %b want 0", resp0_valid); end
      checks++; if (resp1_valid !== 1'b0) begin fails++; $display("FAIL rst_resp1_valid: got %b want 0", resp1_valid); end
      checks++; if (resp0_out !== 32'd0) begin fails++; $display("FAIL rst_resp0_out: got %h want 0", resp0_out); end
      checks++; if ({alu_aluop, alu_porta, alu_portb} !== 68'd0) begin fails++; $display("FAIL rst_alu: got %h %h %h want 0", alu_aluop, alu_porta, alu_portb); end
      tick;
   endtask

   task test_single_op;
      drive(0, 1, ALU_ADD, 5, 7);
      #1;
      checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", req0_ready); end
      tick;
      drive(0, 0, 0, 0, 0);
      #1;
      checks++; if (resp0_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b want 0", resp0_valid); end
      checks++; if (alu_porta !== 32'd5) begin fails++; $display("FAIL single_alu_a: got %h want 5", alu_porta); end
      tick;
      checks++; if (resp0_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", resp0_valid); end
      checks++; if (resp0_out !== 32'd12) begin fails++; $display("FAIL single_out: got %h want c", resp0_out); end
      checks++; if ({resp0_negative, resp0_overflow, resp0_zero} !== 3'b000) begin fails++; $display("FAIL single_flags: got %b want 000", {resp0_negative, resp0_overflow, resp0_zero}); end
      checks++; if (resp1_valid !== 1'b0) begin fails++; $display("FAIL single_resp1: got %b want 0", resp1_valid); end
      tick;
      checks++; if (resp0_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b want 0", resp0_valid); end
   endtask

   task test_flags;
      drive(0, 1, ALU_ADD, 32'h7FFF_FFFF, 1);
      #1;
      checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL flags_ready_a: got %b want 1", req0_ready); end
      tick;
      drive(0, 1, ALU_SUB, 9, 9);
      #1;
      checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL flags_ready_b: got %b want 1", req0_ready); end
      tick;
      drive(0, 0, 0, 0, 0);
      #1;
      checks++; if (resp0_out !== 32'h8000_0000) begin fails++; $display("FAIL flags_ovf_out: got %h want 80000000", resp0_out); end
      checks++; if ({resp0_valid, resp0_negative, resp0_overflow, resp0_zero} !== 4'b1110) begin fails++; $display("FAIL flags_ovf: got %b want 1110", {resp0_valid, resp0_negative, resp0_overflow, resp0_zero}); end
      tick;
      checks++; if (resp0_out !== 32'd0) begin fails++; $display("FAIL flags_zero_out: got %h want 0", resp0_out); end
      checks++; if ({resp0_valid, resp0_negative, resp0_overflow, resp0_zero} !== 4'b1001) begin fails++; $display("FAIL flags_zero: got %b want 1001", {resp0_valid, resp0_negative, resp0_overflow, resp0_zero}); end
      tick;
   endtask

   task test_round_robin;
      logic [31:0] k0, k1;
      RST = 1;
      tick;
      RST = 0;
      k0 = 0;
      k1 = 1;
      for (int c = 0; c < 9; c++) begin
         drive(0, c < 6, ALU_ADD, k0, 1000);
         drive(1, c < 6, ALU_ADD, k1, 1000);
         #1;
         if (c < 6) begin
            checks++; if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL rr_grant c=%0d: got %b%b want %0d", c, req0_ready, req1_ready, c % 2); end
         end
         if (c >= 2 && c < 8) begin
            checks++; if ({resp0_valid, resp1_valid} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL rr_resp_valid c=%0d: got %b%b", c, resp0_valid, resp1_valid); end
            checks++; if ((resp0_out | resp1_out) !== 32'(c - 2 + 1000)) begin fails++; $display("FAIL rr_resp_out c=%0d: got %h want %h", c, resp0_out | resp1_out, c - 2 + 1000); end
         end else if (c == 8) begin
            checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin fails++; $display("FAIL rr_idle: got %b%b want 00", resp0_valid, resp1_valid); end
         end
         tick;
         if (c % 2 == 0) k0 = k0 + 2; else k1 = k1 + 2;
      end
   endtask

   task test_fixed_prio;
      for (int c = 0; c < 4; c++) begin
         drive(0, 1, ALU_ADD, c, 1);
         drive(1, 1, ALU_ADD, c, 2);
         #1;
         checks++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL fixed_grant c=%0d: got %b%b want 10", c, req0_ready, req1_ready); end
         tick;
      end
      drive(0, 0, 0, 0, 0);
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL fixed_release: got %b%b want 01", req0_ready, req1_ready); end
      tick;
      drive(1, 0, 0, 0, 0);
      tick;
      tick;
      tick;
   endtask

   task test_backpressure;
      resp0_ready = 0;
      drive(0, 1, ALU_ADD, 1, 2);
      #1;
      checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL bp_acc_a: got %b want 1", req0_ready); end
      tick;
      drive(0, 0, 0, 0, 0);
      drive(1, 1, ALU_ADD, 10, 20);
      #1;
      checks++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL bp_acc_b: got %b want 1", req1_ready); end
      tick;
      for (int c = 0; c < 3; c++) begin
         drive(0, 1, ALU_SUB, 50 + c, 1);
         drive(1, 1, ALU_XOR, c, 3);
         #1;
         checks++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL bp_ready c=%0d: got %b%b want 00", c, req0_ready, req1_ready); end
         checks++; if ({resp0_valid, resp0_out} !== {1'b1, 32'd3}) begin fails++; $display("FAIL bp_hold c=%0d: got %b %h want 1 3", c, resp0_valid, resp0_out); end
         checks++; if (alu_porta !== 32'd10) begin fails++; $display("FAIL bp_s1 c=%0d: got %h want a", c, alu_porta); end
         tick;
      end
      resp0_ready = 1;
      drive(0, 1, ALU_ADD, 100, 5);
      drive(1, 1, ALU_ADD, 7, 7);
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL bp_ptr: got %b%b want 10", req0_ready, req1_ready); end
      checks++; if ({resp0_valid, resp0_out} !== {1'b1, 32'd3}) begin fails++; $display("FAIL bp_drain_a: got %b %h want 1 3", resp0_valid, resp0_out); end
      tick;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      #1;
      checks++; if ({resp0_valid, resp1_valid, resp1_out} !== {2'b01, 32'd30}) begin fails++; $display("FAIL bp_drain_b: got %b%b %h want 01 1e", resp0_valid, resp1_valid, resp1_out); end
      tick;
      checks++; if ({resp0_valid, resp0_out} !== {1'b1, 32'd105}) begin fails++; $display("FAIL bp_drain_c: got %b %h want 1 69", resp0_valid, resp0_out); end
      tick;
      checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin fails++; $display("FAIL bp_empty: got %b%b want 00", resp0_valid, resp1_valid); end
   endtask

   task test_reset_mid;
      resp0_ready = 0;
      drive(0, 1, ALU_ADD, 1, 1);
      tick;
      drive(0, 1, ALU_ADD, 2, 2);
      #1;
      checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL rm_fill: got %b want 1", req0_ready); end
      tick;
      RST = 1;
      drive(1, 1, ALU_ADD, 3, 3);
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL rm_ready_in_rst: got %b%b want 00", req0_ready, req1_ready); end
      tick;
      RST = 0;
      resp0_ready = 1;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      #1;
      checks++; if ({resp0_valid, resp1_valid, resp0_out} !== 34'd0) begin fails++; $display("FAIL rm_stale: got %b%b %h want 00 0", resp0_valid, resp1_valid, resp0_out); end
      checks++; if ({alu_aluop, alu_porta} !== 36'd0) begin fails++; $display("FAIL rm_alu: got %h %h want 0", alu_aluop, alu_porta); end
      tick;
      drive(0, 1, ALU_ADD, 4, 4);
      drive(1, 1, ALU_ADD, 6, 6);
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL rm_ptr: got %b%b want 10", req0_ready, req1_ready); end
      tick;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      #1;
      checks++; if (resp0_valid !== 1'b0) begin fails++; $display("FAIL rm_latency: got %b want 0", resp0_valid); end
      tick;
      checks++; if ({resp0_valid, resp0_out} !== {1'b1, 32'd8}) begin fails++; $display("FAIL rm_first: got %b %h want 1 8", resp0_valid, resp0_out); end
      tick;
   endtask

   initial begin
      test_reset;
      test_single_op;
      test_flags;
`ifdef ALU_ARB_FIXED_PRIO_EN
      test_fixed_prio;
`else
      test_round_robin;
`endif
      test_backpressure;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
